// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Tracks destination/control bits in a private shadow pipeline beside the datapath.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int BR_IN_EX    = 1,
  parameter int ZERO_REG_HW = 1,
  parameter int COUNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_jump,
  input  logic                  br_taken,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [COUNT_W-1:0]    stall_cnt,
  output logic [COUNT_W-1:0]    flush_cnt
);

  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic                  ex_uses_rs, ex_uses_rt, ex_rw, ex_mr;
  logic                  mem_rw, mem_mr, wb_rw;
  logic                  lu, stall;

  function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                 input logic [REG_ADDR_W-1:0] d);
    return (x == d) && !((ZERO_REG_HW != 0) && (d == '0));
  endfunction

  // EX/MEM wins over MEM/WB; a load sitting in MEM is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic                  uses,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic                  m_rw,
                                         input logic                  m_mr,
                                         input logic [REG_ADDR_W-1:0] m_dest,
                                         input logic                  w_rw,
                                         input logic [REG_ADDR_W-1:0] w_dest);
    if (uses && m_rw && !m_mr && match(src, m_dest))
      return 2'b10;
    else if (uses && w_rw && match(src, w_dest))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    lu = ex_mr && ex_rw &&
         ((id_uses_rs && match(id_rs, ex_dest)) ||
          (id_uses_rt && match(id_rt, ex_dest)));
    stall       = lu && !br_taken;
    stall_pc    = stall;
    stall_ifid  = stall;
    flush_ifid  = br_taken || (id_jump && !lu);
    flush_idex  = br_taken || lu;
    flush_exmem = (BR_IN_EX == 0) && br_taken;
    fwd_a = fwd_sel(ex_uses_rs, ex_rs, mem_rw, mem_mr, mem_dest, wb_rw, wb_dest);
    fwd_b = fwd_sel(ex_uses_rt, ex_rt, mem_rw, mem_mr, mem_dest, wb_rw, wb_dest);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dest    <= '0;
      ex_uses_rs <= 1'b0;
      ex_uses_rt <= 1'b0;
      ex_rw      <= 1'b0;
      ex_mr      <= 1'b0;
      mem_dest   <= '0;
      mem_rw     <= 1'b0;
      mem_mr     <= 1'b0;
      wb_dest    <= '0;
      wb_rw      <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      // Address fields always advance; only the control bits are bubbled.
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_dest    <= id_dest;
      ex_uses_rs <= id_uses_rs   && !flush_idex;
      ex_uses_rt <= id_uses_rt   && !flush_idex;
      ex_rw      <= id_reg_write && !flush_idex;
      ex_mr      <= id_mem_read  && !flush_idex;
      mem_dest   <= ex_dest;
      mem_rw     <= ex_rw && !flush_exmem;
      mem_mr     <= ex_mr && !flush_exmem;
      wb_dest    <= mem_dest;
      wb_rw      <= mem_rw;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + COUNT_W'(1);
      if (flush_ifid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: two configurations share stimulus; a negedge monitor pops expectations.
module tb_pipeline_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       jmp;
  } ins_t;

  typedef struct {
    string      name;
    logic       chk;
    logic [4:0] ca;
    logic [3:0] fa;
    int         sca;
    int         fca;
    logic [4:0] cb;
    logic [3:0] fb;
    int         scb;
    int         fcb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0;
  logic id_mem_read = 1'b0, id_jump = 1'b0, br_taken = 1'b0;

  logic stall_pc_a, stall_ifid_a, flush_ifid_a, flush_idex_a, flush_exmem_a;
  logic [1:0] fwd_a_a, fwd_b_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic stall_pc_b, stall_ifid_b, flush_ifid_b, flush_idex_b, flush_exmem_b;
  logic [1:0] fwd_a_b, fwd_b_b;
  logic [1:0] stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR_W(5), .BR_IN_EX(1), .ZERO_REG_HW(1), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
    .br_taken(br_taken), .stall_pc(stall_pc_a), .stall_ifid(stall_ifid_a),
    .flush_ifid(flush_ifid_a), .flush_idex(flush_idex_a), .flush_exmem(flush_exmem_a),
    .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_unit #(.REG_ADDR_W(5), .BR_IN_EX(0), .ZERO_REG_HW(0), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
    .br_taken(br_taken), .stall_pc(stall_pc_b), .stall_ifid(stall_ifid_b),
    .flush_ifid(flush_ifid_b), .flush_idex(flush_idex_b), .flush_exmem(flush_exmem_b),
    .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        check({e.name, " a.ctl"}, int'({stall_pc_a, stall_ifid_a, flush_ifid_a, flush_idex_a, flush_exmem_a}), int'(e.ca));
        check({e.name, " a.fwd"}, int'({fwd_a_a, fwd_b_a}), int'(e.fa));
        check({e.name, " a.stall_cnt"}, int'(stall_cnt_a), e.sca);
        check({e.name, " a.flush_cnt"}, int'(flush_cnt_a), e.fca);
        check({e.name, " b.ctl"}, int'({stall_pc_b, stall_ifid_b, flush_ifid_b, flush_idex_b, flush_exmem_b}), int'(e.cb));
        check({e.name, " b.fwd"}, int'({fwd_a_b, fwd_b_b}), int'(e.fb));
        check({e.name, " b.stall_cnt"}, int'(stall_cnt_b), e.scb);
        check({e.name, " b.flush_cnt"}, int'(flush_cnt_b), e.fcb);
      end
    end
  end

  function automatic ins_t alu(input int rd, input int rs, input int rt);
    ins_t i = '0;
    i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1;
    i.dest = 5'(rd); i.rw = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(input int rt, input int base);
    ins_t i = '0;
    i.rs = 5'(base); i.urs = 1'b1; i.dest = 5'(rt); i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic ins_t jr(input int rs);
    ins_t i = '0;
    i.rs = 5'(rs); i.urs = 1'b1; i.jmp = 1'b1;
    return i;
  endfunction

  // One pipeline cycle: drive ID inputs just after the edge, queue the expected outputs.
  task automatic cyc(input ins_t i, input logic br, input logic rst, input string nm,
                     input logic chk,
                     input logic [4:0] ca, input logic [3:0] fa, input int sca, input int fca,
                     input logic [4:0] cb, input logic [3:0] fb, input int scb, input int fcb);
    exp_t x;
    @(posedge clk);
    #1;
    id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_dest = i.dest; id_reg_write = i.rw; id_mem_read = i.mr; id_jump = i.jmp;
    br_taken = br; reset = rst;
    x.name = nm; x.chk = chk;
    x.ca = ca; x.fa = fa; x.sca = sca; x.fca = fca;
    x.cb = cb; x.fb = fb; x.scb = scb; x.fcb = fcb;
    sb.push_back(x);
  endtask

  task automatic same(input ins_t i, input logic br, input string nm,
                      input logic [4:0] c, input logic [3:0] f, input int sc, input int fc);
    cyc(i, br, 1'b0, nm, 1'b1, c, f, sc, fc, c, f, sc, fc);
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b1, "reset", 1'b0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  localparam logic [4:0] LU  = 5'b11010;
  localparam logic [4:0] JMP = 5'b00100;

  initial begin
    // lw $2 ; add $3,$2,$4
    do_reset();
    same(lw(2, 1),     1'b0, "lu.idle",  '0, 4'b0000, 0, 0);
    same(alu(3, 2, 4), 1'b0, "lu.stall", LU, 4'b0000, 0, 0);
    same(alu(3, 2, 4), 1'b0, "lu.held",  '0, 4'b0000, 1, 0);
    same('0,           1'b0, "lu.fwd",   '0, 4'b0100, 1, 0);

    // add $2 ; sub $5,$2,$2 then the same pair with one independent instruction between
    do_reset();
    same(alu(2, 6, 7), 1'b0, "exm.c0",  '0, 4'b0000, 0, 0);
    same(alu(5, 2, 2), 1'b0, "exm.c1",  '0, 4'b0000, 0, 0);
    same('0,           1'b0, "exm.fwd", '0, 4'b1010, 0, 0);
    same('0,           1'b0, "exm.c3",  '0, 4'b0000, 0, 0);
    same(alu(2, 6, 7), 1'b0, "mwb.c0",  '0, 4'b0000, 0, 0);
    same(alu(8, 9, 10),1'b0, "mwb.c1",  '0, 4'b0000, 0, 0);
    same(alu(5, 2, 2), 1'b0, "mwb.c2",  '0, 4'b0000, 0, 0);
    same('0,           1'b0, "mwb.fwd", '0, 4'b0101, 0, 0);

    // write $0 then read $0: hard-wired zero in a, ordinary register in b
    do_reset();
    same(alu(0, 6, 7), 1'b0, "zero.c0", '0, 4'b0000, 0, 0);
    same(alu(5, 0, 4), 1'b0, "zero.c1", '0, 4'b0000, 0, 0);
    cyc('0, 1'b0, 1'b0, "zero.fwd", 1'b1, '0, 4'b0000, 0, 0, '0, 4'b1000, 0, 0);
    same('0,           1'b0, "zero.c3", '0, 4'b0000, 0, 0);

    // taken branch coincident with a load-use; b also bubbles MEM
    do_reset();
    same(alu(2, 6, 7), 1'b0, "br.c0", '0, 4'b0000, 0, 0);
    same(lw(9, 1),     1'b0, "br.c1", '0, 4'b0000, 0, 0);
    cyc(alu(3, 9, 2), 1'b1, 1'b0, "br.flush", 1'b1,
        5'b00110, 4'b0000, 0, 0, 5'b00111, 4'b0000, 0, 0);
    same(alu(4, 9, 5), 1'b0, "br.after", '0, 4'b0000, 0, 1);
    cyc('0, 1'b0, 1'b0, "br.mem_bubble", 1'b1,
        '0, 4'b0100, 0, 1, '0, 4'b0000, 0, 1);

    // jr $2 held in ID during a load-use stall
    do_reset();
    same(lw(2, 1), 1'b0, "jmp.c0",    '0,  4'b0000, 0, 0);
    same(jr(2),    1'b0, "jmp.stall", LU,  4'b0000, 0, 0);
    same(jr(2),    1'b0, "jmp.flush", JMP, 4'b0000, 1, 0);
    same('0,       1'b0, "jmp.after", '0,  4'b0100, 1, 1);

    // repeated lw $2,($2): a stall every other cycle, b's 2-bit counter saturates
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      logic [4:0] c;
      logic [3:0] f;
      c = (i % 2 == 1) ? LU : 5'b00000;
      f = (i % 2 == 1 && i >= 3) ? 4'b0100 : 4'b0000;
      cyc(lw(2, 2), 1'b0, 1'b0, $sformatf("sat.c%0d", i), 1'b1,
          c, f, i / 2, 0, c, f, (i / 2 > 3) ? 3 : i / 2, 0);
    end
    cyc(lw(2, 2), 1'b0, 1'b1, "sat.reset_in_stall", 1'b1,
        LU, 4'b0100, 5, 0, LU, 4'b0100, 3, 0);
    same(lw(2, 2), 1'b0, "sat.after_reset", '0, 4'b0000, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
